pe_mac_sequencer: RTL and testbench

- PE-local operand sequencer, directly upstream of the PE multiply-accumulate unit.
- Buffers one filter row of weights and one window of activations in small scratchpads, and accepts an incoming partial sum.
- Drives the MAC's a_in / w_in / sum_in / en for cfg_len back-to-back cycles, feeding each MAC result back as the next sum_in.
- Emits the final partial sum on a valid/ready port. Weights are stationary across windows; activations and psums are reloaded per window.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_spad.sv | 54 +++++
 rtl/pe_mac_sequencer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_pe_mac_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the PE operand sequencer: default sizes, the operand
// word type and the sequencer state encoding.
// -----------------------------------------------------------------------------
package pe_pkg;

    localparam int DEF_DATA_BITWIDTH = 16;
    localparam int DEF_SPAD_DEPTH    = 12;

    typedef logic [DEF_DATA_BITWIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_A  = 3'd2,
        LOAD_P  = 3'd3,
        COMPUTE = 3'd4,
        WAIT    = 3'd5,
        DRAIN   = 3'd6
    } state_t;

endpackage

// File: rtl/pe_spad.sv
// -----------------------------------------------------------------------------
// pe_spad
// Small scratchpad: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address (combinational read)
//   rd_data  : read data, zero for an out-of-range address
// -----------------------------------------------------------------------------
module pe_spad #(
    parameter int DEPTH  = 12,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Guard both ports against addresses beyond the physical depth.
    always_comb begin
        wr_ok_s = ({1'b0, wr_addr} < DEPTH_C);
        rd_ok_s = ({1'b0, rd_addr} < DEPTH_C);
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read.
    always_comb begin
        if (rd_ok_s) begin
            rd_data = mem_r[rd_addr];
        end else begin
            rd_data = ZERO_C;
        end
    end

endmodule

// File: rtl/pe_mac_sequencer.sv
// -----------------------------------------------------------------------------
// pe_mac_sequencer
// Operand sequencer in front of the PE multiply-accumulate unit. Loads a row of
// weights (optionally reused across jobs), then per window loads activations
// and an incoming psum, issues cfg_len back-to-back MACs feeding each MAC
// result back as the next sum, and emits the final psum on a valid/ready port.
//   clk, reset                       : clock, async active-low reset
//   start, cfg_len, cfg_windows,
//   cfg_load_wght                    : job launch and configuration
//   wght_*, act_*, psum_in_*         : input streams (valid/ready)
//   mac_a, mac_w, mac_sum, mac_en    : MAC operands and enable
//   mac_out                          : registered MAC result (1-cycle latency)
//   psum_out_*                       : finished psum (valid/ready)
//   busy, done                       : status
// -----------------------------------------------------------------------------
module pe_mac_sequencer
    import pe_pkg::*;
#(
    parameter int DATA_BITWIDTH    = DEF_DATA_BITWIDTH,
    parameter int MAC_OUT_BITWIDTH = 2*DATA_BITWIDTH,
    parameter int SPAD_DEPTH       = DEF_SPAD_DEPTH,
    parameter int LEN_W            = $clog2(SPAD_DEPTH+1),
    parameter int WIN_W            = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic [WIN_W-1:0]            cfg_windows,
    input  logic                        cfg_load_wght,
    input  logic [DATA_BITWIDTH-1:0]    wght_in,
    input  logic                        wght_valid,
    output logic                        wght_ready,
    input  logic [DATA_BITWIDTH-1:0]    act_in,
    input  logic                        act_valid,
    output logic                        act_ready,
    input  logic [DATA_BITWIDTH-1:0]    psum_in,
    input  logic                        psum_in_valid,
    output logic                        psum_in_ready,
    output logic [DATA_BITWIDTH-1:0]    mac_a,
    output logic [DATA_BITWIDTH-1:0]    mac_w,
    output logic [DATA_BITWIDTH-1:0]    mac_sum,
    output logic                        mac_en,
    input  logic [MAC_OUT_BITWIDTH-1:0] mac_out,
    output logic [DATA_BITWIDTH-1:0]    psum_out,
    output logic                        psum_out_valid,
    input  logic                        psum_out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int                       ADDR_W    = $clog2(SPAD_DEPTH);
    localparam logic [DATA_BITWIDTH-1:0] DATA_ZERO = {DATA_BITWIDTH{1'b0}};
    localparam logic [LEN_W-1:0]         LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]         LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0]         LEN_MAX   = LEN_W'(SPAD_DEPTH);
    localparam logic [WIN_W-1:0]         WIN_ZERO  = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0]         WIN_ONE   = WIN_W'(1);

    state_t                     state_r, state_nxt_s;
    logic [LEN_W-1:0]           idx_r, idx_nxt_s;
    logic [WIN_W-1:0]           win_cnt_r, win_cnt_nxt_s, win_inc_s;
    logic [LEN_W-1:0]           len_r;
    logic [WIN_W-1:0]           win_r;
    logic [DATA_BITWIDTH-1:0]   psum_reg_r;
    logic [DATA_BITWIDTH-1:0]   psum_out_r;
    logic                       cfg_legal_s;
    logic                       idx_last_s;
    logic                       launch_s;
    logic                       wspad_we_s, aspad_we_s, psum_ld_s, last_hs_s;
    logic [DATA_BITWIDTH-1:0]   w_rd_s, a_rd_s;
    logic [DATA_BITWIDTH-1:0]   mac_sum_s;
    logic                       wght_ready_r, act_ready_r, psum_in_ready_r;
    logic                       mac_en_r, psum_out_valid_r, busy_r, done_r;
    logic [DATA_BITWIDTH-1:0]   mac_a_r, mac_w_r;
    logic                       mac_out_hi_unused_s;

    // Only the low word of the MAC result is used; the upper half is dropped (modular wrap).
    assign mac_out_hi_unused_s = ^mac_out[MAC_OUT_BITWIDTH-1:DATA_BITWIDTH];

    // Launch qualification: a start with a zero or oversized length, or zero windows, is dropped.
    always_comb begin
        cfg_legal_s = (cfg_len != LEN_ZERO) && (cfg_len <= LEN_MAX) && (cfg_windows != WIN_ZERO);
        launch_s    = (state_r == IDLE) && start && cfg_legal_s;
        idx_last_s  = (idx_r == (len_r - LEN_ONE));
        win_inc_s   = win_cnt_r + WIN_ONE;
    end

    // Next-state, index and window-count logic.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        win_cnt_nxt_s = win_cnt_r;
        wspad_we_s    = 1'b0;
        aspad_we_s    = 1'b0;
        psum_ld_s     = 1'b0;
        last_hs_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    idx_nxt_s     = LEN_ZERO;
                    win_cnt_nxt_s = WIN_ZERO;
                    state_nxt_s   = cfg_load_wght ? LOAD_W : LOAD_A;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD_W: begin
                if (wght_valid && wght_ready_r) begin
                    wspad_we_s = 1'b1;
                    if (idx_last_s) begin
                        idx_nxt_s   = LEN_ZERO;
                        state_nxt_s = LOAD_A;
                    end else begin
                        idx_nxt_s = idx_r + LEN_ONE;
                    end
                end else begin
                    state_nxt_s = LOAD_W;
                end
            end
            LOAD_A: begin
                if (act_valid && act_ready_r) begin
                    aspad_we_s = 1'b1;
                    if (idx_last_s) begin
                        idx_nxt_s   = LEN_ZERO;
                        state_nxt_s = LOAD_P;
                    end else begin
                        idx_nxt_s = idx_r + LEN_ONE;
                    end
                end else begin
                    state_nxt_s = LOAD_A;
                end
            end
            LOAD_P: begin
                if (psum_in_valid && psum_in_ready_r) begin
                    psum_ld_s   = 1'b1;
                    idx_nxt_s   = LEN_ZERO;
                    state_nxt_s = COMPUTE;
                end else begin
                    state_nxt_s = LOAD_P;
                end
            end
            COMPUTE: begin
                if (idx_last_s) begin
                    idx_nxt_s   = LEN_ZERO;
                    state_nxt_s = WAIT;
                end else begin
                    idx_nxt_s = idx_r + LEN_ONE;
                end
            end
            WAIT: begin
                state_nxt_s = DRAIN;
            end
            DRAIN: begin
                if (psum_out_valid_r && psum_out_ready) begin
                    win_cnt_nxt_s = win_inc_s;
                    if (win_inc_s == win_r) begin
                        last_hs_s   = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = LOAD_A;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                idx_nxt_s     = LEN_ZERO;
                win_cnt_nxt_s = WIN_ZERO;
            end
        endcase
    end

    // State, counters and latched job configuration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            idx_r     <= LEN_ZERO;
            win_cnt_r <= WIN_ZERO;
            len_r     <= LEN_ZERO;
            win_r     <= WIN_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            win_cnt_r <= win_cnt_nxt_s;
            if (launch_s) begin
                len_r <= cfg_len;
                win_r <= cfg_windows;
            end
        end
    end

    // Incoming psum register and output psum capture (final MAC result is visible in WAIT).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psum_reg_r <= DATA_ZERO;
            psum_out_r <= DATA_ZERO;
        end else begin
            if (psum_ld_s) begin
                psum_reg_r <= psum_in;
            end
            if (state_r == WAIT) begin
                psum_out_r <= mac_out[DATA_BITWIDTH-1:0];
            end
        end
    end

    pe_spad #(
        .DEPTH  (SPAD_DEPTH),
        .WIDTH  (DATA_BITWIDTH),
        .ADDR_W (ADDR_W)
    ) u_wspad (
        .clk     (clk),
        .wr_en   (wspad_we_s),
        .wr_addr (idx_r[ADDR_W-1:0]),
        .wr_data (wght_in),
        .rd_addr (idx_nxt_s[ADDR_W-1:0]),
        .rd_data (w_rd_s)
    );

    pe_spad #(
        .DEPTH  (SPAD_DEPTH),
        .WIDTH  (DATA_BITWIDTH),
        .ADDR_W (ADDR_W)
    ) u_aspad (
        .clk     (clk),
        .wr_en   (aspad_we_s),
        .wr_addr (idx_r[ADDR_W-1:0]),
        .wr_data (act_in),
        .rd_addr (idx_nxt_s[ADDR_W-1:0]),
        .rd_data (a_rd_s)
    );

    // Handshake, status and operand outputs are registered from the next state,
    // so each one always matches the state it is presented in. Operands are
    // read from the scratchpads at the next index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wght_ready_r     <= 1'b0;
            act_ready_r      <= 1'b0;
            psum_in_ready_r  <= 1'b0;
            mac_en_r         <= 1'b0;
            mac_a_r          <= DATA_ZERO;
            mac_w_r          <= DATA_ZERO;
            psum_out_valid_r <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            wght_ready_r     <= (state_nxt_s == LOAD_W);
            act_ready_r      <= (state_nxt_s == LOAD_A);
            psum_in_ready_r  <= (state_nxt_s == LOAD_P);
            mac_en_r         <= (state_nxt_s == COMPUTE);
            mac_a_r          <= (state_nxt_s == COMPUTE) ? a_rd_s : DATA_ZERO;
            mac_w_r          <= (state_nxt_s == COMPUTE) ? w_rd_s : DATA_ZERO;
            psum_out_valid_r <= (state_nxt_s == DRAIN);
            busy_r           <= (state_nxt_s != IDLE);
            done_r           <= last_hs_s;
        end
    end

    // Sum operand: the loaded psum for the first MAC, then the MAC's own
    // previous result (combinational, relies on its 1-cycle registered latency).
    always_comb begin
        if (state_r == COMPUTE) begin
            if (idx_r == LEN_ZERO) begin
                mac_sum_s = psum_reg_r;
            end else begin
                mac_sum_s = mac_out[DATA_BITWIDTH-1:0];
            end
        end else begin
            mac_sum_s = DATA_ZERO;
        end
    end

    assign wght_ready     = wght_ready_r;
    assign act_ready      = act_ready_r;
    assign psum_in_ready  = psum_in_ready_r;
    assign mac_en         = mac_en_r;
    assign mac_a          = mac_a_r;
    assign mac_w          = mac_w_r;
    assign mac_sum        = mac_sum_s;
    assign psum_out       = psum_out_r;
    assign psum_out_valid = psum_out_valid_r;
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
module tb_pe_mac_sequencer;
    import pe_pkg::*;

    localparam int DW     = 16;
    localparam int MW     = 32;
    localparam int SD     = 12;
    localparam int LEN_W  = $clog2(SD+1);
    localparam int WIN_W  = 8;
    localparam int BUDGET = 300;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic [WIN_W-1:0] cfg_windows;
    logic             cfg_load_wght;
    data_t            wght_in, act_in, psum_in;
    logic             wght_valid, act_valid, psum_in_valid;
    logic             wght_ready, act_ready, psum_in_ready;
    data_t            mac_a, mac_w, mac_sum;
    logic             mac_en;
    logic [MW-1:0]    mac_out;
    data_t            psum_out;
    logic             psum_out_valid, psum_out_ready;
    logic             busy, done;

    always #5 clk = ~clk;

    pe_mac_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
        .cfg_windows(cfg_windows), .cfg_load_wght(cfg_load_wght),
        .wght_in(wght_in), .wght_valid(wght_valid), .wght_ready(wght_ready),
        .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready),
        .psum_in(psum_in), .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
        .mac_a(mac_a), .mac_w(mac_w), .mac_sum(mac_sum), .mac_en(mac_en),
        .mac_out(mac_out), .psum_out(psum_out), .psum_out_valid(psum_out_valid),
        .psum_out_ready(psum_out_ready), .busy(busy), .done(done)
    );

    // Behavioural MAC: registered a*w+sum, holds when not enabled.
    always @(posedge clk or negedge reset) begin
        if (!reset) mac_out <= '0;
        else if (mac_en) mac_out <= MW'(mac_a) * MW'(mac_w) + MW'(mac_sum);
    end

    typedef struct { data_t a; data_t w; data_t s; } trip_t;
    trip_t mac_q[$];
    int    run_q[$];
    data_t out_q[$];

    int    vectors = 0, miscompares = 0;
    int    wx_cnt = 0, ax_cnt = 0, out_cnt = 0, done_cnt = 0, run_len = 0;
    int    stored_len = 0;
    data_t last_out;
    logic  prev_valid = 1'b0, prev_hs = 1'b0;
    data_t prev_data;
    data_t wmem[SD];
    data_t amem[SD];
    data_t job_a[4][SD];
    data_t job_p[4];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops for MAC operands, run lengths and output psums.
    always @(negedge clk) begin
        if (reset) begin
            chk("ready_onehot", 64'($countones({wght_ready, act_ready, psum_in_ready}) <= 1), 64'd1);
            if (mac_en || psum_out_valid)
                chk("ready_outside_load", {wght_ready, act_ready, psum_in_ready}, 64'd0);
            if (wght_valid && wght_ready) wx_cnt++;
            if (act_valid && act_ready) ax_cnt++;
            if (done) done_cnt++;
            if (mac_en) begin
                if (mac_q.size() == 0) begin
                    chk("mac_en_unexpected", mac_en, 64'd0);
                end else begin
                    trip_t t;
                    t = mac_q.pop_front();
                    chk("mac_a", mac_a, t.a);
                    chk("mac_w", mac_w, t.w);
                    chk("mac_sum", mac_sum, t.s);
                end
                run_len++;
            end else begin
                chk("mac_idle_zero", {mac_a, mac_w, mac_sum}, 64'd0);
                if (run_len > 0) begin
                    if (run_q.size() == 0) chk("mac_run_unexpected", 64'(run_len), 64'd0);
                    else chk("mac_run_len", 64'(run_len), 64'(run_q.pop_front()));
                    run_len = 0;
                end
            end
            if (psum_out_valid && prev_valid && !prev_hs)
                chk("psum_out_stable", psum_out, prev_data);
            if (psum_out_valid && psum_out_ready) begin
                out_cnt++;
                last_out = psum_out;
                if (out_q.size() == 0) chk("psum_out_unexpected", psum_out_valid, 64'd0);
                else chk("psum_out", psum_out, out_q.pop_front());
            end
            prev_valid = psum_out_valid;
            prev_data  = psum_out;
            prev_hs    = psum_out_valid && psum_out_ready;
        end else begin
            run_len    = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end
    end

    function automatic logic rdy(input int which);
        case (which)
            0: return wght_ready;
            1: return act_ready;
            default: return psum_in_ready;
        endcase
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Reference model: each MAC sees the running modular sum of psum + a*w terms.
    task automatic push_window_expect(input int len, input data_t ps);
        data_t acc;
        acc = ps;
        for (int i = 0; i < len; i++) begin
            mac_q.push_back('{a: amem[i], w: wmem[i], s: acc});
            acc = data_t'(acc + amem[i] * wmem[i]);
        end
        run_q.push_back(len);
        out_q.push_back(acc);
    endtask

    task automatic xfer(input int which, input data_t v, input int gap);
        int n;
        repeat (gap) step();
        case (which)
            0: begin wght_in = v; wght_valid = 1'b1; end
            1: begin act_in = v; act_valid = 1'b1; end
            default: begin psum_in = v; psum_in_valid = 1'b1; end
        endcase
        n = 0;
        while (!rdy(which) && n < BUDGET) begin step(); n++; end
        if (!rdy(which)) chk("xfer_timeout", rdy(which), 64'd1);
        else step();
        wght_valid = 1'b0; act_valid = 1'b0; psum_in_valid = 1'b0;
    endtask

    task automatic collect(input int stall);
        int n;
        n = 0;
        while (!psum_out_valid && n < BUDGET) begin step(); n++; end
        if (!psum_out_valid) begin
            chk("psum_out_timeout", psum_out_valid, 64'd1);
        end else begin
            repeat (stall) step();
            psum_out_ready = 1'b1;
            step();
            psum_out_ready = 1'b0;
        end
    endtask

    task automatic launch(input int len, input int windows, input bit load);
        int n;
        n = 0;
        while (busy && n < BUDGET) begin step(); n++; end
        if (busy) chk("idle_timeout", busy, 64'd0);
        cfg_len = LEN_W'(len); cfg_windows = WIN_W'(windows); cfg_load_wght = load;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_job(input int len, input int windows, input bit load,
                           input int gap, input int stall, input bit dup_start);
        int wx0, ax0, out0, done0;
        wx0 = wx_cnt; ax0 = ax_cnt; out0 = out_cnt; done0 = done_cnt;
        launch(len, windows, load);
        if (dup_start) begin
            step();
            cfg_len = LEN_W'(3); cfg_windows = WIN_W'(1); cfg_load_wght = 1'b0;
            start = 1'b1;
            step();
            start = 1'b0;
        end
        if (load) begin
            for (int i = 0; i < len; i++) xfer(0, wmem[i], $urandom_range(0, gap));
            if (len > stored_len) stored_len = len;
        end
        for (int w = 0; w < windows; w++) begin
            for (int i = 0; i < len; i++) amem[i] = job_a[w][i];
            push_window_expect(len, job_p[w]);
            for (int i = 0; i < len; i++) xfer(1, amem[i], $urandom_range(0, gap));
            xfer(2, job_p[w], $urandom_range(0, gap));
            collect(stall);
        end
        step(); step();
        chk("done_pulses", 64'(done_cnt - done0), 64'd1);
        chk("wght_xfers", 64'(wx_cnt - wx0), load ? 64'(len) : 64'd0);
        chk("act_xfers", 64'(ax_cnt - ax0), 64'(len * windows));
        chk("out_xfers", 64'(out_cnt - out0), 64'(windows));
        chk("queues_drained", 64'(mac_q.size() + out_q.size() + run_q.size()), 64'd0);
        chk("busy_after_job", busy, 64'd0);
    endtask

    task automatic rand_window(input int w, input int len);
        for (int i = 0; i < len; i++) job_a[w][i] = data_t'($urandom);
        job_p[w] = data_t'($urandom);
    endtask

    task automatic rand_weights(input int len);
        for (int i = 0; i < len; i++) wmem[i] = data_t'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; cfg_len = '0; cfg_windows = '0; cfg_load_wght = 1'b0;
        wght_in = '0; act_in = '0; psum_in = '0;
        wght_valid = 1'b0; act_valid = 1'b0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
        repeat (3) step();
        chk("reset_outputs", {wght_ready, act_ready, psum_in_ready, mac_en, psum_out_valid,
                              busy, done, mac_a, mac_w, mac_sum, psum_out}, 64'd0);
        reset = 1'b1;
        step();

        // Directed: weights 2,3,4, acts 1,1,1, psum 10 -> sums 10,12,15, out 19.
        wmem[0] = 16'd2; wmem[1] = 16'd3; wmem[2] = 16'd4;
        job_a[0][0] = 16'd1; job_a[0][1] = 16'd1; job_a[0][2] = 16'd1; job_p[0] = 16'd10;
        run_job(3, 1, 1'b1, 0, 0, 1'b0);
        chk("t1_psum_value", last_out, 64'd19);

        // Two windows with weight load, then weight reuse: acts 5,0,0 psum 0 -> 10.
        rand_window(0, 3); rand_window(1, 3);
        run_job(3, 2, 1'b1, 2, 1, 1'b0);
        job_a[0][0] = 16'd5; job_a[0][1] = 16'd0; job_a[0][2] = 16'd0; job_p[0] = 16'd0;
        run_job(3, 1, 1'b0, 0, 0, 1'b0);
        chk("t2_reuse_psum", last_out, 64'd10);

        // Random valid gaps and a 5-cycle output stall.
        rand_weights(5); rand_window(0, 5); rand_window(1, 5);
        run_job(5, 2, 1'b1, 3, 5, 1'b0);

        // Overflow wrap: 0x8000*2 + 1 -> 0x0001.
        wmem[0] = 16'h8000; job_a[0][0] = 16'd2; job_p[0] = 16'h0001;
        run_job(1, 1, 1'b1, 0, 0, 1'b0);
        chk("t4_wrap_psum", last_out, 64'h1);

        // Reset during COMPUTE at idx 1 aborts the job.
        rand_weights(4); rand_window(0, 4);
        launch(4, 1, 1'b1);
        for (int i = 0; i < 4; i++) xfer(0, wmem[i], 0);
        for (int i = 0; i < 4; i++) amem[i] = job_a[0][i];
        push_window_expect(4, job_p[0]);
        for (int i = 0; i < 4; i++) xfer(1, amem[i], 0);
        xfer(2, job_p[0], 0);
        n = 0;
        while (!mac_en && n < BUDGET) begin step(); n++; end
        chk("t5_compute_reached", mac_en, 64'd1);
        step();
        reset = 1'b0;
        #1;
        chk("t5_abort_outputs", {wght_ready, act_ready, psum_in_ready, mac_en, psum_out_valid,
                                 busy, done}, 64'd0);
        mac_q.delete(); run_q.delete(); out_q.delete();
        stored_len = 0;
        step(); step();
        chk("t5_held_outputs", {mac_en, psum_out_valid, busy}, 64'd0);
        reset = 1'b1;
        step();
        rand_weights(4); rand_window(0, 4);
        run_job(4, 1, 1'b1, 1, 0, 1'b0);

        // Full-depth length with a start pulse while busy (must be ignored).
        rand_weights(12); rand_window(0, 12);
        run_job(12, 1, 1'b1, 0, 2, 1'b1);

        // Randomised jobs.
        for (int j = 0; j < 8; j++) begin
            int len, wins;
            bit load;
            len  = $urandom_range(1, SD);
            wins = $urandom_range(1, 3);
            load = (stored_len < len) ? 1'b1 : 1'(($urandom_range(0, 1)));
            if (load) rand_weights(len);
            for (int w = 0; w < wins; w++) rand_window(w, len);
            run_job(len, wins, load, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
